// File: rtl/day01_pkg.sv
// Shared defaults and FSM state type for the day01 ROM arbiter.
package day01_pkg;

    localparam int DAY01_DEPTH  = 973;
    localparam int DAY01_ADDR_W = 16;
    localparam int DAY01_DATA_W = 64;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

endpackage

// File: rtl/day01_rom_arbiter.sv
// Two-requester round-robin arbiter in front of a shared combinational ROM:
// grant and address register in IDLE, ROM read and response capture in ISSUE.
module day01_rom_arbiter
    import day01_pkg::*;
#(
    parameter int DEPTH  = DAY01_DEPTH,
    parameter int ADDR_W = DAY01_ADDR_W,
    parameter int DATA_W = DAY01_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0,
    input  logic                     req1,
    input  logic [ADDR_W-1:0]        addr0,
    input  logic [ADDR_W-1:0]        addr1,
    output logic                     gnt0,
    output logic                     gnt1,
    output logic                     rvalid0,
    output logic                     rvalid1,
    output logic signed [DATA_W-1:0] rdata0,
    output logic signed [DATA_W-1:0] rdata1,
    output logic                     err0,
    output logic                     err1,
    output logic [ADDR_W-1:0]        rom_addr,
    output logic                     rom_en,
    input  logic signed [DATA_W-1:0] rom_data
);

    state_t state;
    state_t next_state;
    logic   grant_any;
    logic   grant_one;
    logic   prio_one;
    logic   addr_ok;

    assign addr_ok = (32'(rom_addr) < 32'(DEPTH));
    assign rom_en  = (state == ISSUE) && addr_ok;

    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        next_state = state;
        grant_any  = 1'b0;
        grant_one  = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    next_state = ISSUE;
                    grant_any  = 1'b1;
                    grant_one  = req1 && (!req0 || prio_one);
                end
            end
            ISSUE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // gnt stays high exactly for the ISSUE cycle, so it also identifies the owner of the read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            err0     <= 1'b0;
            err1     <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
            rom_addr <= '0;
            prio_one <= 1'b0;
        end else begin
            gnt0    <= grant_any && !grant_one;
            gnt1    <= grant_any && grant_one;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            err0    <= 1'b0;
            err1    <= 1'b0;
            if (grant_any) begin
                rom_addr <= grant_one ? addr1 : addr0;
                prio_one <= !grant_one;
            end
            if (state == ISSUE) begin
                if (gnt1) begin
                    rvalid1 <= 1'b1;
                    err1    <= !addr_ok;
                    rdata1  <= addr_ok ? rom_data : '0;
                end else begin
                    rvalid0 <= 1'b1;
                    err0    <= !addr_ok;
                    rdata0  <= addr_ok ? rom_data : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_day01_rom_arbiter.sv
// Directed bench for day01_rom_arbiter with a ROM model returning addr + 100.
module tb_day01_rom_arbiter;

    logic               clk = 1'b0;
    logic               rst;
    logic               req0, req1;
    logic [15:0]        addr0, addr1;
    logic               gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic signed [63:0] rdata0, rdata1;
    logic [15:0]        rom_addr;
    logic               rom_en;
    logic signed [63:0] rom_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign rom_data = 64'(rom_addr) + 64'd100;

    day01_rom_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .req1     (req1),
        .addr0    (addr0),
        .addr1    (addr1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .err0     (err0),
        .err1     (err1),
        .rom_addr (rom_addr),
        .rom_en   (rom_en),
        .rom_data (rom_data)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        addr0 = '0;
        addr1 = '0;
        tick();
        tick();
        check("rst_gnt",    {gnt0, gnt1},       2'b00);
        check("rst_rvalid", {rvalid0, rvalid1}, 2'b00);
        check("rst_rdata0", rdata0,             64'd0);
        check("rst_romaddr", rom_addr,          16'd0);
        check("rst_romen",  rom_en,             1'b0);
        rst = 1'b0;

        // Idle with no request
        tick();
        check("idle_gnt",   {gnt0, gnt1, rvalid0, rvalid1, err0, err1}, 6'b0);
        check("idle_romen", rom_en, 1'b0);

        // Single read from requester 0
        req0 = 1'b1; addr0 = 16'd5;
        tick();
        check("single_gnt",     {gnt0, gnt1}, 2'b10);
        check("single_romen",   rom_en,       1'b1);
        check("single_romaddr", rom_addr,     16'd5);
        check("single_rv_early", rvalid0,     1'b0);
        req0 = 1'b0;
        tick();
        check("single_gnt_off", {gnt0, gnt1}, 2'b00);
        check("single_rvalid",  {rvalid0, rvalid1}, 2'b10);
        check("single_rdata0",  rdata0, 64'd105);
        check("single_err0",    err0,   1'b0);
        check("single_romen_idle", rom_en, 1'b0);
        tick();
        check("single_rv_pulse", rvalid0,  1'b0);
        check("single_hold",     rdata0,   64'd105);
        check("idle_romaddr_hold", rom_addr, 16'd5);

        // Boundary: last valid address, then first invalid one
        req1 = 1'b1; addr1 = 16'd972;
        tick();
        check("b972_gnt",   {gnt0, gnt1}, 2'b01);
        check("b972_romen", rom_en,       1'b1);
        req1 = 1'b0;
        tick();
        check("b972_rvalid", {rvalid0, rvalid1}, 2'b01);
        check("b972_rdata1", rdata1, 64'd1072);
        check("b972_err1",   err1,   1'b0);
        req1 = 1'b1; addr1 = 16'd973;
        tick();
        check("b973_gnt",     {gnt0, gnt1}, 2'b01);
        check("b973_romen",   rom_en,       1'b0);
        check("b973_romaddr", rom_addr,     16'd973);
        req1 = 1'b0;
        tick();
        check("b973_rvalid",  {rvalid0, rvalid1}, 2'b01);
        check("b973_rdata1",  rdata1, 64'd0);
        check("b973_err1",    err1,   1'b1);
        check("b973_romen_idle", rom_en, 1'b0);
        check("b973_rdata0_keep", rdata0, 64'd105);

        // Contention: last grant went to 1, so 0 wins first and they alternate
        req0 = 1'b1; req1 = 1'b1; addr0 = 16'd1; addr1 = 16'd2;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("cont_gnt",       {gnt0, gnt1},       (k % 2 == 0) ? 2'b10 : 2'b01);
            check("cont_rv_issue",  {rvalid0, rvalid1}, 2'b00);
            if (k == 3) begin
                req0 = 1'b0; req1 = 1'b0;
            end
            tick();
            check("cont_gnt_idle",  {gnt0, gnt1},       2'b00);
            check("cont_rvalid",    {rvalid0, rvalid1}, (k % 2 == 0) ? 2'b10 : 2'b01);
            check("cont_rdata",     (k % 2 == 0) ? rdata0 : rdata1,
                  (k % 2 == 0) ? 64'd101 : 64'd102);
        end
        tick();
        check("cont_done", {gnt0, gnt1, rvalid0, rvalid1}, 4'b0);

        // Back-to-back on requester 0 with req held; address changes during ISSUE are ignored
        req0 = 1'b1; addr0 = 16'd7;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("b2b_gnt", {gnt0, gnt1}, 2'b10);
            addr0 = 16'd500;
            if (k == 2) req0 = 1'b0;
            tick();
            check("b2b_rvalid", {rvalid0, rvalid1}, 2'b10);
            check("b2b_rdata0", rdata0, 64'(107 + k));
            check("b2b_rdata1_keep", rdata1, 64'd102);
            addr0 = 16'(8 + k);
        end
        tick();
        check("b2b_done", {gnt0, gnt1, rvalid0}, 3'b0);

        // Reset during ISSUE discards the read
        req1 = 1'b1; addr1 = 16'd3;
        tick();
        check("rmid_gnt", {gnt0, gnt1}, 2'b01);
        rst = 1'b1;
        #1;
        check("rmid_gnt_clr", {gnt0, gnt1, rvalid0, rvalid1, err0, err1}, 6'b0);
        check("rmid_romen",   rom_en,   1'b0);
        check("rmid_romaddr", rom_addr, 16'd0);
        check("rmid_rdata",   {rdata0, rdata1}, 128'd0);
        req1 = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("rmid_no_rvalid", {gnt0, gnt1, rvalid0, rvalid1}, 4'b0);
        req0 = 1'b1; req1 = 1'b1; addr0 = 16'd10; addr1 = 16'd11;
        tick();
        check("rmid_prio0", {gnt0, gnt1}, 2'b10);
        req0 = 1'b0; req1 = 1'b0;
        tick();
        check("rmid_rvalid", {rvalid0, rvalid1}, 2'b10);
        check("rmid_rdata0", rdata0, 64'd110);
        check("rmid_rdata1", rdata1, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
